// File: rtl/adder_tree9.sv
// Pipelined 9-input adder tree: sums nine partial products of a 3x3 window.
// Four register stages, one operand set per clock, fixed 4-cycle latency.
module adder_tree9 #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  partial_product1,
  input  logic [IN_W-1:0]  partial_product2,
  input  logic [IN_W-1:0]  partial_product3,
  input  logic [IN_W-1:0]  partial_product4,
  input  logic [IN_W-1:0]  partial_product5,
  input  logic [IN_W-1:0]  partial_product6,
  input  logic [IN_W-1:0]  partial_product7,
  input  logic [IN_W-1:0]  partial_product8,
  input  logic [IN_W-1:0]  partial_product9,
  output logic             out_valid,
  output logic [OUT_W-1:0] sum
);

  generate
    if (OUT_W < IN_W + 4) begin : g_width_check
      $error("adder_tree9: OUT_W must be >= IN_W+4");
    end
  endgenerate

  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
    if (SIGNED != 0) ext = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
    else             ext = {{(OUT_W-IN_W){1'b0}}, x};
  endfunction

  logic [OUT_W-1:0] op [9];
  logic [3:0]       vld;
  logic [OUT_W-1:0] s1 [5];
  logic [OUT_W-1:0] s2 [3];
  logic [OUT_W-1:0] s3 [2];

  always_comb begin
    op[0] = ext(partial_product1);
    op[1] = ext(partial_product2);
    op[2] = ext(partial_product3);
    op[3] = ext(partial_product4);
    op[4] = ext(partial_product5);
    op[5] = ext(partial_product6);
    op[6] = ext(partial_product7);
    op[7] = ext(partial_product8);
    op[8] = ext(partial_product9);
  end

  // vld[k] marks that stage k+1 holds a fresh set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= {vld[2:0], in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) s1[i] <= '0;
    end else if (in_valid) begin
      s1[0] <= op[0] + op[1];
      s1[1] <= op[2] + op[3];
      s1[2] <= op[4] + op[5];
      s1[3] <= op[6] + op[7];
      s1[4] <= op[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) s2[i] <= '0;
    end else if (vld[0]) begin
      s2[0] <= s1[0] + s1[1];
      s2[1] <= s1[2] + s1[3];
      s2[2] <= s1[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3[0] <= '0;
      s3[1] <= '0;
    end else if (vld[1]) begin
      s3[0] <= s2[0] + s2[1];
      s3[1] <= s2[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum <= '0;
    else if (vld[2]) sum <= s3[0] + s3[1];
  end

  assign out_valid = vld[3];

endmodule

// File: tb/tb_adder_tree9.sv
// Self-checking bench for adder_tree9: unsigned and signed instances share stimulus.
// Reference is a whole-sum delay line plus directed constants and ordered queues.
module tb_adder_tree9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] pp [9];
  logic        ov_u, ov_s;
  logic [19:0] sum_u, sum_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_tree9 #(.IN_W(16), .OUT_W(20), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .partial_product1(pp[0]), .partial_product2(pp[1]), .partial_product3(pp[2]),
    .partial_product4(pp[3]), .partial_product5(pp[4]), .partial_product6(pp[5]),
    .partial_product7(pp[6]), .partial_product8(pp[7]), .partial_product9(pp[8]),
    .out_valid(ov_u), .sum(sum_u));

  adder_tree9 #(.IN_W(16), .OUT_W(20), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .partial_product1(pp[0]), .partial_product2(pp[1]), .partial_product3(pp[2]),
    .partial_product4(pp[3]), .partial_product5(pp[4]), .partial_product6(pp[5]),
    .partial_product7(pp[6]), .partial_product8(pp[7]), .partial_product9(pp[8]),
    .out_valid(ov_s), .sum(sum_s));

  function automatic logic [19:0] ref_u();
    int unsigned t = 0;
    for (int i = 0; i < 9; i++) t += pp[i];
    return t[19:0];
  endfunction

  function automatic logic [19:0] ref_s();
    int t = 0;
    for (int i = 0; i < 9; i++) t += int'($signed(pp[i]));
    return t[19:0];
  endfunction

  // Reference: complete sums delayed by the pipeline latency, held between results
  typedef struct packed { logic v; logic [19:0] su; logic [19:0] ss; } ent_t;
  ent_t        h [3];
  logic        exp_v;
  logic [19:0] exp_su, exp_ss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) h[i] <= '0;
      exp_v <= 1'b0; exp_su <= '0; exp_ss <= '0;
    end else begin
      h[0] <= '{in_valid, ref_u(), ref_s()};
      h[1] <= h[0];
      h[2] <= h[1];
      exp_v <= h[2].v;
      if (h[2].v) begin
        exp_su <= h[2].su;
        exp_ss <= h[2].ss;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_rand();
    for (int i = 0; i < 9; i++) pp[i] = 16'($urandom);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 9; i++) pp[i] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_rand(); cyc();
      n_checks++;
      if (ov_u !== 1'b0 || sum_u !== 20'h0 || ov_s !== 1'b0 || sum_s !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_hold: ov_u=%b sum_u=%h ov_s=%b sum_s=%h, want 0", ov_u, sum_u, ov_s, sum_s);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin set_rand(); cyc(); end
    // pipeline now full and non-zero; reset lands between edges
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov_u !== 1'b0 || sum_u !== 20'h0 || ov_s !== 1'b0 || sum_s !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async: ov_u=%b sum_u=%h ov_s=%b sum_s=%h, want 0", ov_u, sum_u, ov_s, sum_s);
    end
    in_valid = 1'b0;
    cyc(); rst_n = 1'b1; cyc();
  endtask

  task automatic test_directed();
    pp[0] = 16'h1234; pp[1] = 16'h5678; pp[2] = 16'h9abc; pp[3] = 16'hdef0;
    pp[4] = 16'h1234; pp[5] = 16'h5678; pp[6] = 16'h9abc; pp[7] = 16'hdef0;
    pp[8] = 16'h1111;
    in_valid = 1'b1;
    cyc(); in_valid = 1'b0; set_rand();
    cyc(); cyc();
    n_checks++;
    if (ov_u !== 1'b0) begin
      n_fail++; $display("FAIL directed_early: out_valid=%b want 0", ov_u);
    end
    cyc();
    n_checks++;
    if (ov_u !== 1'b1 || sum_u !== 20'h3D5C1) begin
      n_fail++; $display("FAIL directed_sum: ov=%b sum=%h want ov=1 sum=3d5c1", ov_u, sum_u);
    end
    cyc(); cyc();
    n_checks++;
    if (ov_u !== 1'b0 || sum_u !== 20'h3D5C1) begin
      n_fail++; $display("FAIL directed_hold: ov=%b sum=%h want ov=0 sum=3d5c1", ov_u, sum_u);
    end
  endtask

  // Single pulse with value v on every operand; checks both instances 4 edges later
  task automatic pulse_check(input string name, input logic [19:0] want_u, input logic [19:0] want_s);
    in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++;
    if (ov_u !== 1'b1 || sum_u !== want_u) begin
      n_fail++; $display("FAIL %s_u: ov=%b sum=%h want ov=1 sum=%h", name, ov_u, sum_u, want_u);
    end
    n_checks++;
    if (ov_s !== 1'b1 || sum_s !== want_s) begin
      n_fail++; $display("FAIL %s_s: ov=%b sum=%h want ov=1 sum=%h", name, ov_s, sum_s, want_s);
    end
    cyc();
  endtask

  task automatic test_max();
    set_all(16'hFFFF); pulse_check("max_ones", 20'h8FFF7, 20'hFFFF7);
    set_all(16'h0000); pulse_check("all_zero", 20'h00000, 20'h00000);
  endtask

  task automatic test_signed();
    set_all(16'h8000); pulse_check("min_neg", 20'h48000, 20'hB8000);
    set_all(16'h0000); pp[0] = 16'hFFFF;
    pulse_check("minus_one", 20'h0FFFF, 20'hFFFFF);
  endtask

  task automatic test_back_to_back();
    logic [19:0] qu [$];
    logic [19:0] qs [$];
    int run = 0;
    for (int k = 0; k < 26; k++) begin
      if (k < 20) begin
        set_rand(); in_valid = 1'b1;
        qu.push_back(ref_u()); qs.push_back(ref_s());
      end else begin
        in_valid = 1'b0; set_rand();
      end
      cyc();
      // negedge k follows edge E+k of the first set
      if (k >= 3 && k <= 22) begin
        n_checks++;
        if (ov_u !== 1'b1 || qu.size() == 0) begin
          n_fail++; $display("FAIL stream_valid[%0d]: ov=%b want 1", k, ov_u);
        end else begin
          logic [19:0] wu, ws;
          wu = qu.pop_front(); ws = qs.pop_front();
          run++;
          n_checks++;
          if (sum_u !== wu || sum_s !== ws) begin
            n_fail++;
            $display("FAIL stream_sum[%0d]: sum_u=%h sum_s=%h want %h %h", k, sum_u, sum_s, wu, ws);
          end
        end
      end else begin
        n_checks++;
        if (ov_u !== 1'b0) begin
          n_fail++; $display("FAIL stream_gap[%0d]: ov=%b want 0", k, ov_u);
        end
      end
    end
    n_checks++;
    if (run !== 20) begin
      n_fail++; $display("FAIL stream_count: got %0d results want 20", run);
    end
  endtask

  task automatic test_bubbles();
    logic        pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [19:0] last_u;
    last_u = sum_u;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) in_valid = pat[k]; else in_valid = 1'b0;
      set_rand();
      cyc();
      if (k >= 3 && k < 8) begin
        n_checks++;
        if (ov_u !== pat[k-3]) begin
          n_fail++; $display("FAIL bubble_valid[%0d]: ov=%b want %b", k, ov_u, pat[k-3]);
        end
        if (!pat[k-3]) begin
          n_checks++;
          if (sum_u !== last_u) begin
            n_fail++; $display("FAIL bubble_hold[%0d]: sum=%h want %h", k, sum_u, last_u);
          end
        end
        last_u = sum_u;
      end
      n_checks++;
      if (ov_u !== exp_v || sum_u !== exp_su || ov_s !== exp_v || sum_s !== exp_ss) begin
        n_fail++;
        $display("FAIL bubble_model[%0d]: ov=%b/%b sum=%h/%h want ov=%b sum=%h/%h",
                 k, ov_u, ov_s, sum_u, sum_s, exp_v, exp_su, exp_ss);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    for (int k = 0; k < 3; k++) begin set_rand(); in_valid = 1'b1; cyc(); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (ov_u === 1'b1 || ov_s === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midstream_reset: %0d out_valid cycles want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(16'h0);
    test_reset();
    test_directed();
    test_max();
    test_signed();
    test_back_to_back();
    test_bubbles();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
